// File: rtl/mem_result_checker.sv
// Sequential memory result checker: after a settle delay, reads NUM_CHECKS consecutive words
// and compares them against a loadable expected-value table. Optional CHK_MASK_EN adds per-entry bit masks.
module mem_result_checker #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_CHECKS   = 22,
  parameter int BASE_ADDR    = 11,
  parameter int DELAY_CYCLES = 75
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  exp_we,
  input  logic [7:0]            exp_idx,
  input  logic [DATA_WIDTH-1:0] exp_data,
`ifdef CHK_MASK_EN
  input  logic [DATA_WIDTH-1:0] exp_mask,
`endif
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  all_pass,
  output logic                  first_fail_valid,
  output logic [8:0]            pass_cnt,
  output logic [8:0]            fail_cnt,
  output logic [7:0]            first_fail_idx
);

  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam int DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, DELAY, ISSUE, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [DLY_W-1:0] delay_cnt_q, delay_cnt_d;
  logic [8:0]       pass_cnt_q, pass_cnt_d;
  logic [8:0]       fail_cnt_q, fail_cnt_d;
  logic             ffv_q, ffv_d;
  logic [7:0]       ffi_q, ffi_d;

  logic             idle_like;
  logic             tbl_we;
  logic             match;

  logic [DATA_WIDTH-1:0] exp_table [NUM_CHECKS];
`ifdef CHK_MASK_EN
  logic [DATA_WIDTH-1:0] mask_table [NUM_CHECKS];
`endif

  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign tbl_we    = exp_we && idle_like && ({1'b0, exp_idx} < 9'(NUM_CHECKS));

  // NOTE: the table is plain storage with no reset so it maps onto RAM and survives a reset.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      exp_table[exp_idx[IDX_W-1:0]]  <= exp_data;
`ifdef CHK_MASK_EN
      mask_table[exp_idx[IDX_W-1:0]] <= exp_mask;
`endif
    end
  end

`ifdef CHK_MASK_EN
  assign match = ((mem_rd_data ^ exp_table[idx_q[IDX_W-1:0]]) & mask_table[idx_q[IDX_W-1:0]]) == '0;
`else
  assign match = (mem_rd_data == exp_table[idx_q[IDX_W-1:0]]);
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      delay_cnt_q <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      ffv_q       <= 1'b0;
      ffi_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      delay_cnt_q <= delay_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      ffv_q       <= ffv_d;
      ffi_q       <= ffi_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    delay_cnt_d = delay_cnt_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    ffv_d       = ffv_q;
    ffi_d       = ffi_q;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pass_cnt_d  = '0;
          fail_cnt_d  = '0;
          ffv_d       = 1'b0;
          idx_d       = '0;
          delay_cnt_d = '0;
          state_d     = (DELAY_CYCLES == 0) ? ISSUE : DELAY;
        end
      end
      DELAY: begin
        if (delay_cnt_q == DLY_W'(DELAY_CYCLES - 1)) begin
          state_d = ISSUE;
        end else begin
          delay_cnt_d = delay_cnt_q + 1'b1;
        end
      end
      ISSUE: begin
        mem_rd_en = 1'b1;
        mem_addr  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx_q);
        state_d   = CHECK;
      end
      CHECK: begin
        if (match) begin
          pass_cnt_d = pass_cnt_q + 9'd1;
        end else begin
          fail_cnt_d = fail_cnt_q + 9'd1;
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = idx_q;
          end
        end
        if (idx_q == 8'(NUM_CHECKS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy             = (state_q == DELAY) || (state_q == ISSUE) || (state_q == CHECK);
  assign done             = (state_q == DONE);
  assign all_pass         = done && (fail_cnt_q == 9'd0);
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;
  assign pass_cnt         = pass_cnt_q;
  assign fail_cnt         = fail_cnt_q;

endmodule

// File: tb/tb_mem_result_checker.sv
// Directed self-checking bench for mem_result_checker with default parameters and a
// one-cycle-latency memory model. Masked-compare step runs only when CHK_MASK_EN is defined.
module tb_mem_result_checker;

  localparam int N      = 22;
  localparam int BASE   = 11;
  localparam int DLY    = 75;
  localparam int DONE_C = DLY + 2 * N + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        exp_we;
  logic [7:0]  exp_idx;
  logic [31:0] exp_data;
`ifdef CHK_MASK_EN
  logic [31:0] exp_mask;
`endif
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rd_data;
  logic        busy, done, all_pass, first_fail_valid;
  logic [8:0]  pass_cnt, fail_cnt;
  logic [7:0]  first_fail_idx;

  logic [31:0] mem [256];
  logic [31:0] tbl [N];
  int          total = 0;
  int          bad   = 0;

  mem_result_checker dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .exp_we           (exp_we),
    .exp_idx          (exp_idx),
    .exp_data         (exp_data),
`ifdef CHK_MASK_EN
    .exp_mask         (exp_mask),
`endif
    .mem_rd_en        (mem_rd_en),
    .mem_addr         (mem_addr),
    .mem_rd_data      (mem_rd_data),
    .busy             (busy),
    .done             (done),
    .all_pass         (all_pass),
    .first_fail_valid (first_fail_valid),
    .pass_cnt         (pass_cnt),
    .fail_cnt         (fail_cnt),
    .first_fail_idx   (first_fail_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_exp(input logic [7:0] idx, input logic [31:0] data);
    exp_we   = 1'b1;
    exp_idx  = idx;
    exp_data = data;
    tick();
    exp_we   = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_allp"},  {31'd0, all_pass}, 32'd0);
    check({tag, "_ffv"},   {31'd0, first_fail_valid}, 32'd0);
    check({tag, "_pass"},  {23'd0, pass_cnt}, 32'd0);
    check({tag, "_fail"},  {23'd0, fail_cnt}, 32'd0);
    check({tag, "_ffi"},   {24'd0, first_fail_idx}, 32'd0);
    check({tag, "_rden"},  {31'd0, mem_rd_en}, 32'd0);
    check({tag, "_addr"},  {24'd0, mem_addr}, 32'd0);
  endtask

  // Runs one pass. glitch_c: cycle in which start and a busy-time table write are injected (0 = none).
  task automatic run_pass(input string tag, input int glitch_c, input int exp_pass, input int exp_fail,
                          input logic exp_ffv, input logic [7:0] exp_ffi);
    int c;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    while (!done && c < 400) begin
      if (c == 1) begin
        check({tag, "_dly_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_dly_rden"}, {31'd0, mem_rd_en}, 32'd0);
      end
      if (c == DLY + 1) begin
        check({tag, "_iss_rden"}, {31'd0, mem_rd_en}, 32'd1);
        check({tag, "_iss_addr"}, {24'd0, mem_addr}, BASE);
      end
      if (c == glitch_c) begin
        start    = 1'b1;
        exp_we   = 1'b1;
        exp_idx  = 8'd3;
        exp_data = 32'hdeadbeef;
      end
      tick();
      start  = 1'b0;
      exp_we = 1'b0;
      c++;
    end
    check({tag, "_done_cycle"}, c, DONE_C);
    check({tag, "_pass"}, {23'd0, pass_cnt}, exp_pass);
    check({tag, "_fail"}, {23'd0, fail_cnt}, exp_fail);
    check({tag, "_allp"}, {31'd0, all_pass}, (exp_fail == 0) ? 32'd1 : 32'd0);
    check({tag, "_ffv"},  {31'd0, first_fail_valid}, {31'd0, exp_ffv});
    if (exp_ffv) check({tag, "_ffi"}, {24'd0, first_fail_idx}, {24'd0, exp_ffi});
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    exp_we   = 1'b0;
    exp_idx  = '0;
    exp_data = '0;
`ifdef CHK_MASK_EN
    exp_mask = 32'hffffffff;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 32'h5555_0000 + i;
    for (int i = 0; i < N; i++) tbl[i] = 32'h3c5a_0000 + i * 32'h0001_0f03;
    tbl[0]  = 32'h0fd76e00;
    tbl[1]  = 32'hf02891ee;
    tbl[2]  = 32'h00000001;
    tbl[4]  = 32'h00000000;
    tbl[21] = 32'hb54bc031;
    tick();
    tick();
    reset = 1'b0;
    check_cleared("reset");

    for (int i = 0; i < N; i++) begin
      write_exp(8'(i), tbl[i]);
      mem[BASE + i] = tbl[i];
    end
    // Out-of-range index aliasing entry 2 in the low bits must be dropped.
    write_exp(8'd34, 32'hbad0bad0);

    run_pass("basic", 0, 22, 0, 1'b0, 8'd0);

    mem[15] = 32'h00000001;
    run_pass("one_miss", 0, 21, 1, 1'b1, 8'd4);
    mem[15] = tbl[4];

    mem[13] = ~tbl[2];
    mem[20] = ~tbl[9];
    run_pass("two_miss", 0, 20, 2, 1'b1, 8'd2);
    mem[13] = tbl[2];
    mem[20] = tbl[9];

    run_pass("glitch", DLY + 2, 22, 0, 1'b0, 8'd0);
    run_pass("tbl_kept", 0, 22, 0, 1'b0, 8'd0);

    // Table write in the same cycle as start must land before entry 0 is checked.
    tbl[0]   = 32'h12345678;
    mem[11]  = tbl[0];
    exp_we   = 1'b1;
    exp_idx  = 8'd0;
    exp_data = tbl[0];
    run_pass("we_start", 0, 22, 0, 1'b0, 8'd0);

    begin
      logic saw_done;
      saw_done = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 80; c++) begin
        saw_done |= done;
        tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_no_done", {31'd0, saw_done}, 32'd0);
      check_cleared("abort");
    end
    run_pass("after_abort", 0, 22, 0, 1'b0, 8'd0);

`ifdef CHK_MASK_EN
    exp_we   = 1'b1;
    exp_idx  = 8'd5;
    exp_data = 32'h0fd70000;
    exp_mask = 32'hffff0000;
    tick();
    exp_we   = 1'b0;
    exp_mask = 32'hffffffff;
    mem[16]  = 32'h0fd76e10;
    run_pass("masked", 0, 22, 0, 1'b0, 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
